main_ext_mem: RTL and testbench

MAIN_EXT_MEM -- requirements
Module: main_ext_mem

---
 rtl/main_ext_mem.sv | 189 ++++++++++++++++++
 tb/tb_main_ext_mem.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/main_ext_mem.sv
// Two-channel byte-wide external memory model with per-channel read/write latency,
// bit-masked partial writes, a preload port and a sticky both-enables protocol error.
module main_ext_mem #(
    parameter int BASE_ADDR       = 0,
    parameter int MEMSIZE         = 256,
    parameter int MEM_DELAY_READ  = 2,
    parameter int MEM_DELAY_WRITE = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  Mout_oe_ram,
    input  logic [1:0]  Mout_we_ram,
    input  logic [21:0] Mout_addr_ram,
    input  logic [15:0] Mout_Wdata_ram,
    input  logic [7:0]  Mout_data_ram_size,
    input  logic        load_en,
    input  logic [10:0] load_addr,
    input  logic [7:0]  load_data,
    output logic [15:0] M_Rdata_ram,
    output logic [1:0]  M_DataRdy,
    output logic        err_both_en
);

    localparam int AW = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam int CHAIN = (MEM_DELAY_READ > 1) ? MEM_DELAY_READ - 1 : 1;
    localparam logic [11:0] WIN_LO = 12'(BASE_ADDR);
    localparam logic [11:0] WIN_HI = 12'(BASE_ADDR + MEMSIZE);
    localparam logic [11:0] LOAD_HI = 12'(MEMSIZE);
    localparam logic [3:0] RD_LAST = 4'(MEM_DELAY_READ - 1);
    localparam logic [3:0] WR_LAST = 4'(MEM_DELAY_WRITE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    logic [7:0] mem [MEMSIZE];

    logic [1:0]         in_win;
    logic [1:0]         req_rd;
    logic [1:0]         req_wr;
    logic [1:0]         rdy;
    logic [1:0]         wr_commit;
    logic [1:0][AW-1:0] offs;
    logic [1:0][7:0]    wdata;
    logic [1:0][7:0]    wmask;
    logic [1:0][7:0]    rd_byte;
    logic [1:0][7:0]    rd_out;

    logic err_q;
    logic err_d;
    logic load_ok;

    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic [11:0] addr12;
        logic [3:0]  size;
        logic [3:0]  idx;
        logic [7:0]  chain_out;
        state_t      state_q;
        state_t      state_d;
        logic [2:0]  cnt_q;
        logic [2:0]  cnt_d;

        assign addr12       = {1'b0, Mout_addr_ram[gi*11 +: 11]};
        assign in_win[gi]   = (addr12 >= WIN_LO) && (addr12 < WIN_HI);
        assign offs[gi]     = AW'(addr12 - WIN_LO);
        assign req_rd[gi]   = Mout_oe_ram[gi] & ~Mout_we_ram[gi] & in_win[gi];
        assign req_wr[gi]   = Mout_we_ram[gi] & ~Mout_oe_ram[gi] & in_win[gi];
        assign wdata[gi]    = Mout_Wdata_ram[gi*8 +: 8];
        assign size         = Mout_data_ram_size[gi*4 +: 4];
        assign wmask[gi]    = size[3] ? 8'hFF : 8'((9'd1 << size) - 9'd1);
        assign rd_byte[gi]  = in_win[gi] ? mem[offs[gi]] : 8'h00;

        // idx is the 0-based position of this cycle within the current request;
        // the IDLE cycle that accepts a request is position 0.
        assign idx = (state_q == IDLE) ? 4'd0 : ({1'b0, cnt_q} + 4'd1);

        assign rdy[gi] = (req_rd[gi] && (state_q != WR_WAIT) && (idx == RD_LAST)) ||
                         (req_wr[gi] && (state_q != RD_WAIT) && (idx == WR_LAST));
        assign wr_commit[gi] = rdy[gi] & req_wr[gi] & ~reset;

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            unique case (state_q)
                IDLE: begin
                    cnt_d = 3'd0;
                    if (req_rd[gi] && !rdy[gi]) begin
                        state_d = RD_WAIT;
                    end else if (req_wr[gi] && !rdy[gi]) begin
                        state_d = WR_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (!req_rd[gi] || rdy[gi]) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                WR_WAIT: begin
                    if (!req_wr[gi] || rdy[gi]) begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end
            endcase
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                state_q <= IDLE;
                cnt_q   <= 3'd0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        if (MEM_DELAY_READ > 1) begin : g_chain
            // The memory byte is sampled every cycle so the value that appears at
            // Rdy is the one addressed at the first cycle of the request.
            logic [7:0] chain_q [CHAIN];
            logic [7:0] chain_d [CHAIN];

            always_comb begin
                chain_d[0] = rd_byte[gi];
                for (int i = 1; i < CHAIN; i++) begin
                    chain_d[i] = chain_q[i-1];
                end
            end

            always_ff @(posedge clock) begin
                for (int i = 0; i < CHAIN; i++) begin
                    if (reset) begin
                        chain_q[i] <= 8'h00;
                    end else begin
                        chain_q[i] <= chain_d[i];
                    end
                end
            end

            assign chain_out = chain_q[CHAIN-1];
        end else begin : g_nochain
            assign chain_out = rd_byte[gi];
        end

        assign rd_out[gi] = (rdy[gi] && req_rd[gi]) ? chain_out : 8'h00;
        assign M_Rdata_ram[gi*8 +: 8] = rd_out[gi];
    end

    assign M_DataRdy = rdy;

    assign err_d = err_q | (|(Mout_oe_ram & Mout_we_ram));

    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_both_en = err_q;

    assign load_ok = ({1'b0, load_addr} < LOAD_HI);

    // Later assignments win: ch1 over ch0, and the preload over both. Every merge
    // uses the pre-edge byte, so a same-cycle read still sees the old value.
    always_ff @(posedge clock) begin
        for (int c = 0; c < 2; c++) begin
            if (wr_commit[c]) begin
                mem[offs[c]] <= (wdata[c] & wmask[c]) | (mem[offs[c]] & ~wmask[c]);
            end
        end
        if (load_en && load_ok) begin
            mem[load_addr[AW-1:0]] <= load_data;
        end
    end

endmodule

// File: tb/tb_main_ext_mem.sv
// Bench for main_ext_mem: a directed vector table, randomized traffic checked against
// a transaction-level model of the memory, and hand sequences for error and reset.
module tb_main_ext_mem;

    localparam int RDD = 2;
    localparam int WRD = 1;
    localparam int MSZ = 256;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  oe;
    logic [1:0]  we;
    logic [21:0] addr;
    logic [15:0] wdata;
    logic [7:0]  size;
    logic        load_en;
    logic [10:0] load_addr;
    logic [7:0]  load_data;
    logic [15:0] rdata;
    logic [1:0]  rdy;
    logic        err;

    always #5 clock = ~clock;

    main_ext_mem dut (
        .clock              (clock),
        .reset              (reset),
        .Mout_oe_ram        (oe),
        .Mout_we_ram        (we),
        .Mout_addr_ram      (addr),
        .Mout_Wdata_ram     (wdata),
        .Mout_data_ram_size (size),
        .load_en            (load_en),
        .load_addr          (load_addr),
        .load_data          (load_data),
        .M_Rdata_ram        (rdata),
        .M_DataRdy          (rdy),
        .err_both_en        (err)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: memory image, per-channel request streak, read-sample history.
    logic [7:0] mem_m [MSZ];
    int         kind_m [2];
    int         age_m [2];
    bit         fired_m [2];
    logic [7:0] hist_m [2][8];
    bit         err_m;

    logic [1:0]  m_rdy;
    logic [15:0] m_rd;
    int          m_kind [2];
    int          m_age [2];
    logic [7:0]  m_samp [2];

    logic [1:0]  s_rdy;
    logic [15:0] s_rd;
    logic        s_err;

    typedef struct {
        logic [1:0]  oe;
        logic [1:0]  we;
        logic [10:0] a0;
        logic [10:0] a1;
        logic [7:0]  w0;
        logic [7:0]  w1;
        logic [3:0]  s0;
        logic [3:0]  s1;
        logic        ld;
        logic [10:0] la;
        logic [7:0]  ldat;
        logic [1:0]  e_rdy;
        logic [15:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [1:0] o, logic [1:0] w, int a0, int a1,
                                int w0, int w1, int s0, int s1, logic ld, int la,
                                int ldat, logic [1:0] er, int erd);
        vec_t v;
        v.oe = o; v.we = w;
        v.a0 = 11'(a0); v.a1 = 11'(a1);
        v.w0 = 8'(w0); v.w1 = 8'(w1);
        v.s0 = 4'(s0); v.s1 = 4'(s1);
        v.ld = ld; v.la = 11'(la); v.ldat = 8'(ldat);
        v.e_rdy = er; v.e_rd = 16'(erd);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] mask_of(logic [3:0] s);
        int m;
        m = (s >= 8) ? 255 : ((1 << s) - 1);
        return 8'(m);
    endfunction

    task automatic model_eval();
        logic [10:0] a;
        bit win;
        bit busy;
        bit dead;
        int k;
        int lat;
        logic [7:0] rv;
        for (int c = 0; c < 2; c++) begin
            a    = addr[c*11 +: 11];
            win  = (a < MSZ);
            k    = (oe[c] && !we[c] && win) ? 1 : ((we[c] && !oe[c] && win) ? 2 : 0);
            busy = (kind_m[c] != 0) && !fired_m[c];
            // Switching between read and write mid-request costs one idle cycle.
            dead = (k != 0) && busy && (k != kind_m[c]);
            m_age[c]  = ((k != 0) && busy && (k == kind_m[c])) ? age_m[c] + 1 : 0;
            m_kind[c] = dead ? 0 : k;
            lat = (k == 1) ? RDD : WRD;
            m_rdy[c]  = (k != 0) && !dead && (m_age[c] == lat - 1);
            m_samp[c] = win ? mem_m[a[7:0]] : 8'h00;
            rv = (RDD == 1) ? m_samp[c] : hist_m[c][RDD-2];
            m_rd[c*8 +: 8] = (m_rdy[c] && k == 1) ? rv : 8'h00;
        end
    endtask

    task automatic model_commit();
        logic [7:0] nv [2];
        logic [7:0] old;
        logic [10:0] a;
        for (int c = 0; c < 2; c++) begin
            a = addr[c*11 +: 11];
            old = mem_m[a[7:0]];
            nv[c] = (wdata[c*8 +: 8] & mask_of(size[c*4 +: 4])) |
                    (old & ~mask_of(size[c*4 +: 4]));
        end
        if (reset) begin
            err_m = 1'b0;
            for (int c = 0; c < 2; c++) begin
                kind_m[c] = 0; age_m[c] = 0; fired_m[c] = 1'b0;
                for (int i = 0; i < 8; i++) hist_m[c][i] = 8'h00;
            end
        end else begin
            err_m = err_m | (|(oe & we));
            for (int c = 0; c < 2; c++) begin
                a = addr[c*11 +: 11];
                if (m_rdy[c] && m_kind[c] == 2) mem_m[a[7:0]] = nv[c];
                kind_m[c]  = m_kind[c];
                age_m[c]   = m_age[c];
                fired_m[c] = m_rdy[c];
                for (int i = 7; i > 0; i--) hist_m[c][i] = hist_m[c][i-1];
                hist_m[c][0] = m_samp[c];
            end
        end
        if (load_en && load_addr < MSZ) mem_m[load_addr[7:0]] = load_data;
    endtask

    task automatic step(input bit use_tbl, input logic [1:0] t_rdy,
                        input logic [15:0] t_rd, input string nm);
        @(negedge clock);
        model_eval();
        s_rdy = rdy; s_rd = rdata; s_err = err;
        chk({nm, ".rdy"},   {14'd0, rdy}, {14'd0, use_tbl ? t_rdy : m_rdy});
        chk({nm, ".rdata"}, rdata, use_tbl ? t_rd : m_rd);
        chk({nm, ".err"},   {15'd0, err}, {15'd0, err_m});
        for (int c = 0; c < 2; c++) begin
            if (m_rdy[c]) begin
                $display("[TB] cyc %0d %s ch%0d %s addr=%0d rdata=%h", cyc, nm, c,
                         (m_kind[c] == 1) ? "rd" : "wr", addr[c*11 +: 11], rdata[c*8 +: 8]);
            end
        end
        @(posedge clock);
        model_commit();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        oe = 2'b00; we = 2'b00; addr = 22'd0; wdata = 16'd0; size = 8'd0;
        load_en = 1'b0; load_addr = 11'd0; load_data = 8'd0;
    endtask

    function automatic logic [10:0] pick_addr();
        int r;
        r = $urandom_range(19);
        if (r < 16) return 11'(r);
        if (r == 16) return 11'd255;
        if (r == 17) return 11'd256;
        if (r == 18) return 11'd300;
        return 11'd2047;
    endfunction

    initial begin
        for (int i = 0; i < MSZ; i++) mem_m[i] = 8'h00;
        for (int c = 0; c < 2; c++) begin
            kind_m[c] = 0; age_m[c] = 0; fired_m[c] = 1'b0;
            for (int i = 0; i < 8; i++) hist_m[c][i] = 8'h00;
        end
        err_m = 1'b0;

        // oe, we, a0, a1, w0, w1, s0, s1, ld, la, ldat, exp rdy, exp rdata
        tbl.push_back(mk(2'b00, 2'b00,   0,   0, 0, 0, 0, 0, 1'b1,   3, 8'hA5, 2'b00, 16'h0000));
        tbl.push_back(mk(2'b00, 2'b00,   0,   0, 0, 0, 0, 0, 1'b1,   7, 8'hFF, 2'b00, 16'h0000));
        tbl.push_back(mk(2'b00, 2'b00,   0,   0, 0, 0, 0, 0, 1'b1,  44, 8'h12, 2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   3,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   3,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b01, 16'h00A5));
        tbl.push_back(mk(2'b00, 2'b10,   0,   5, 0, 8'h3C, 0, 8, 1'b0, 0, 0,   2'b10, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   5,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   5,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b01, 16'h003C));
        tbl.push_back(mk(2'b00, 2'b01,   7,   0, 8'h00, 0, 4, 0, 1'b0, 0, 0,   2'b01, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   7,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   7,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b01, 16'h00F0));
        tbl.push_back(mk(2'b00, 2'b01,   7,   0, 8'h00, 0, 0, 0, 1'b0, 0, 0,   2'b01, 16'h0000));
        tbl.push_back(mk(2'b10, 2'b00,   0,   7, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b10, 2'b00,   0,   7, 0, 0, 0, 0, 1'b0,   0, 0,     2'b10, 16'hF000));
        tbl.push_back(mk(2'b00, 2'b11,   9,   9, 8'h11, 8'h22, 8, 8, 1'b0, 0, 0, 2'b11, 16'h0000));
        tbl.push_back(mk(2'b10, 2'b00,   0,   9, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b10, 2'b00,   0,   9, 0, 0, 0, 0, 1'b0,   0, 0,     2'b10, 16'h2200));
        tbl.push_back(mk(2'b01, 2'b10,   3,   3, 0, 8'h55, 0, 8, 1'b0, 0, 0,   2'b10, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b10,   3,   3, 0, 8'h66, 0, 8, 1'b0, 0, 0,   2'b11, 16'h00A5));
        tbl.push_back(mk(2'b01, 2'b00,   3,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   3,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b01, 16'h0066));
        tbl.push_back(mk(2'b00, 2'b01,  10,   0, 8'h77, 0, 8, 0, 1'b1, 10, 8'h88, 2'b01, 16'h0000));
        tbl.push_back(mk(2'b10, 2'b00,   0,  10, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b10, 2'b00,   0,  10, 0, 0, 0, 0, 1'b0,   0, 0,     2'b10, 16'h8800));
        tbl.push_back(mk(2'b00, 2'b00,   0,   0, 0, 0, 0, 0, 1'b1, 300, 8'h99, 2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,  44,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,  44,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b01, 16'h0012));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(2'b01, 2'b00, 300, 0, 0, 0, 0, 0, 1'b0, 0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   2,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b00, 2'b00,   0,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   3,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,   3,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b01, 16'h0066));
        tbl.push_back(mk(2'b00, 2'b10,   0, 300, 0, 8'hEE, 0, 8, 1'b0, 0, 0,   2'b00, 16'h0000));
        tbl.push_back(mk(2'b00, 2'b10,   0, 256, 0, 8'hEE, 0, 8, 1'b0, 0, 0,   2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,  44,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b00, 16'h0000));
        tbl.push_back(mk(2'b01, 2'b00,  44,   0, 0, 0, 0, 0, 1'b0,   0, 0,     2'b01, 16'h0012));

        idle_inputs();
        reset = 1'b1;
        #1;
        step(1'b0, 2'b00, 16'h0, "reset0");
        step(1'b0, 2'b00, 16'h0, "reset1");
        reset = 1'b0;
        step(1'b1, 2'b00, 16'h0, "after_reset");

        for (int r = 0; r < tbl.size(); r++) begin
            oe = tbl[r].oe; we = tbl[r].we;
            addr = {tbl[r].a1, tbl[r].a0};
            wdata = {tbl[r].w1, tbl[r].w0};
            size = {tbl[r].s1, tbl[r].s0};
            load_en = tbl[r].ld; load_addr = tbl[r].la; load_data = tbl[r].ldat;
            step(1'b1, tbl[r].e_rdy, tbl[r].e_rd, $sformatf("vec%0d", r));
        end
        idle_inputs();

        // Preload the random-traffic window with random bytes.
        for (int i = 0; i < 17; i++) begin
            load_en = 1'b1;
            load_addr = (i == 16) ? 11'd255 : 11'(i);
            load_data = 8'($urandom);
            step(1'b0, 2'b00, 16'h0, "preload");
        end
        idle_inputs();

        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < 2; c++) begin
                if ($urandom_range(3) == 0) begin
                    int r;
                    r = $urandom_range(9);
                    oe[c] = (r < 4);
                    we[c] = (r >= 4 && r < 8);
                    addr[c*11 +: 11] = pick_addr();
                    wdata[c*8 +: 8] = 8'($urandom);
                    size[c*4 +: 4] = 4'($urandom_range(15));
                end
            end
            load_en = ($urandom_range(9) == 0);
            load_addr = pick_addr();
            load_data = 8'($urandom);
            step(1'b0, 2'b00, 16'h0, "rand");
        end
        idle_inputs();
        step(1'b0, 2'b00, 16'h0, "drain");

        // Both enables on ch0: no access, sticky error until reset.
        oe = 2'b01; we = 2'b01; addr = 22'd3; wdata = 16'h00FF; size = 8'h08;
        step(1'b0, 2'b00, 16'h0, "both_en");
        chk("both_en.rdy0", {15'd0, s_rdy[0]}, 16'd0);
        idle_inputs();
        step(1'b0, 2'b00, 16'h0, "err_hold0");
        chk("err_set", {15'd0, s_err}, 16'd1);
        step(1'b0, 2'b00, 16'h0, "err_hold1");
        step(1'b0, 2'b00, 16'h0, "err_hold2");
        chk("err_sticky", {15'd0, s_err}, 16'd1);
        reset = 1'b1;
        step(1'b0, 2'b00, 16'h0, "err_reset");
        reset = 1'b0;
        step(1'b0, 2'b00, 16'h0, "err_cleared");
        chk("err_clear", {15'd0, s_err}, 16'd0);

        // A write whose commit edge coincides with reset must not land.
        load_en = 1'b1; load_addr = 11'd4; load_data = 8'h5A;
        step(1'b0, 2'b00, 16'h0, "abort_pre");
        idle_inputs();
        we = 2'b10; addr = {11'd4, 11'd0}; wdata = 16'hC300; size = 8'h80;
        reset = 1'b1;
        step(1'b0, 2'b00, 16'h0, "abort_wr");
        reset = 1'b0;
        idle_inputs();
        oe = 2'b01; addr = 22'd4;
        step(1'b0, 2'b00, 16'h0, "abort_rd0");
        step(1'b0, 2'b00, 16'h0, "abort_rd1");
        chk("abort_no_commit", s_rd, 16'h005A);
        idle_inputs();
        step(1'b0, 2'b00, 16'h0, "end");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
